fault_reconfig_ctrl: RTL and testbench
======================================

Name: fault_reconfig_ctrl

Overview:
Sequencing controller placed after the ECC fault monitor. It counts flagged words inside a sliding cycle window. When the count reaches a threshold, it drains the active core, requests a reconfiguration onto the next core, and then holds a cooldown before it resumes monitoring. It turns per-word reconfiguration triggers into one managed, rate-limited core switchover.

Parameters:
- ERR_THRESH, 4: faults within one window that start a switchover (range 1..255).
- WINDOW, 256: window length in cycles; the fault count clears at each window end.
- COOLDOWN, 64: cycles spent in COOLDOWN after a switchover.
- DRAIN_TIMEOUT, 1024: maximum DRAIN cycles before a forced reconfiguration.
- NUM_CORES, 2: number of selectable cores; active_core wraps modulo this value.
- CORE_W, 1: width of active_core, equal to clog2(NUM_CORES), minimum 1.

Ports:
- clk, input, 1: sole clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous active-low reset, sampled on the clk rising edge.
- chk_valid, input, 1: a checked word is present this cycle.
- chk_fault, input, 1: fault-monitor trigger for that word; qualified by chk_valid.
- chk_data, input, 8: corrected data from the fault monitor; used only when FAULT_LOG_EN is defined.
- drain_req, output, 1: asks the active core to finish and quiesce.
- core_idle, input, 1: the active core is quiesced.
- reconfig_req, output, 1: level request to switch to the next core.
- reconfig_ack, input, 1: one-cycle acknowledge that the switch is complete.
- active_core, output, CORE_W: index of the core currently in use.
- err_count, output, 8: faults counted in the current window.
- fault_irq, output, 1: one-cycle pulse on entry to DRAIN.
- timeout_err, output, 1: sticky flag; set when a drain times out.
- ctrl_state, output, 2: FSM state code.
- total_faults, output, 16: lifetime fault count (optional feature).
- last_bad_data, output, 8: chk_data of the most recent fault (optional feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs take their reset values on that edge.
  - State MONITOR; err_count, window counter, cooldown and timeout counters = 0.
  - drain_req=0, reconfig_req=0, fault_irq=0, timeout_err=0, active_core=0, total_faults=0, last_bad_data=0.
- Reset mid-operation aborts any DRAIN, RECONFIG or COOLDOWN immediately; reconfig_req drops on the reset edge.
- State encoding: MONITOR=00, DRAIN=01, RECONFIG=10, COOLDOWN=11. All outputs are registered.
- MONITOR:
  - The window counter increments every cycle and wraps from WINDOW-1 to 0.
  - A fault event is chk_valid=1 and chk_fault=1; each event increments err_count on that edge.
  - At the wrap edge err_count loads 0. If a fault arrives on the wrap cycle, err_count loads 1 instead.
  - When the incremented err_count equals ERR_THRESH, the same edge moves to DRAIN, drives drain_req=1, and pulses fault_irq for one cycle.
  - Latency: drain_req is high in the cycle after the threshold-reaching fault is sampled.
  - err_count saturates at 255.
- DRAIN:
  - drain_req=1; the timeout counter runs.
  - core_idle=1 moves to RECONFIG on the next edge: drain_req=0, reconfig_req=1.
  - If DRAIN_TIMEOUT cycles elapse without core_idle, move to RECONFIG anyway and set timeout_err.
  - If core_idle and the timeout arrive in the same cycle, core_idle wins and timeout_err stays clear.
- RECONFIG:
  - reconfig_req holds high until reconfig_ack is seen.
  - On ack: reconfig_req=0; active_core advances to (active_core+1) mod NUM_CORES, wrapping NUM_CORES-1 to 0.
  - On the same edge, clear the cooldown counter and enter COOLDOWN.
  - An ack in any other state is ignored.
- COOLDOWN:
  - Counts COOLDOWN cycles, then returns to MONITOR with err_count=0 and the window counter at 0.
- Fault events in DRAIN, RECONFIG and COOLDOWN are not counted in err_count.
- timeout_err clears only on reset.

Optional Feature:
FAULT_LOG_EN
- Defined: every fault event in any state increments total_faults, saturating at 16'hFFFF, and loads last_bad_data from chk_data on the same edge.
- Not defined: both ports still exist and are tied to 0; no logging registers are built.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with chk_fault=1 and chk_valid=1 → after release, err_count=0, ctrl_state=00, active_core=0, and all request outputs are 0.
- Threshold: 4 fault events on cycles 10, 20, 30, 40 → drain_req=1 and a one-cycle fault_irq pulse at cycle 41; err_count=4.
- Window clear: 3 faults, then a wait past the WINDOW=256 boundary, then 1 fault → err_count=1 and no DRAIN; a fault exactly on the wrap cycle → err_count=1.
- Full switchover: reach threshold, core_idle=1 after 5 cycles, reconfig_ack after 3 cycles → active_core=1, then 64 COOLDOWN cycles with faults ignored, then ctrl_state=00 with err_count=0. A second switchover wraps active_core back to 0.
- Drain timeout: never assert core_idle → after 1024 DRAIN cycles, reconfig_req=1 and timeout_err=1 (sticky through later switchovers). Asserting core_idle on the timeout cycle leaves timeout_err=0.
- FAULT_LOG_EN defined: faults with chk_data 8'hA5, then 8'h3C, one of them during COOLDOWN → total_faults=2, last_bad_data=8'h3C. Without the macro → both outputs read 0.

Source files
------------

// File: rtl/fault_reconfig_ctrl.sv
// Windowed fault counter that sequences drain -> reconfig -> cooldown; all outputs registered, drain_req one cycle after the threshold fault.
// Waits indefinitely on reconfig_ack; the drain is bounded by DRAIN_TIMEOUT. FAULT_LOG_EN adds lifetime fault count / last bad data capture.
module fault_reconfig_ctrl #(
  parameter int ERR_THRESH    = 4,
  parameter int WINDOW        = 256,
  parameter int COOLDOWN      = 64,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int NUM_CORES     = 2,
  parameter int CORE_W        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_valid,
  input  logic              chk_fault,
  input  logic [7:0]        chk_data,
  output logic              drain_req,
  input  logic              core_idle,
  output logic              reconfig_req,
  input  logic              reconfig_ack,
  output logic [CORE_W-1:0] active_core,
  output logic [7:0]        err_count,
  output logic              fault_irq,
  output logic              timeout_err,
  output logic [1:0]        ctrl_state,
  output logic [15:0]       total_faults,
  output logic [7:0]        last_bad_data
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int TO_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CORE_W-1:0] CORE_LAST = CORE_W'(NUM_CORES - 1);
  localparam logic [7:0]        THRESH    = 8'(ERR_THRESH);

  typedef enum logic [1:0] {
    S_MONITOR  = 2'b00,
    S_DRAIN    = 2'b01,
    S_RECONFIG = 2'b10,
    S_COOLDOWN = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [7:0]         err_q, err_d;
  logic [CORE_W-1:0]  core_q, core_d;
  logic               drain_q, drain_d;
  logic               rreq_q, rreq_d;
  logic               irq_q, irq_d;
  logic               terr_q, terr_d;

  logic               fault_ev;
  logic               win_wrap;
  logic [7:0]         err_inc;
  logic [CORE_W-1:0]  core_next;

  assign fault_ev  = chk_valid & chk_fault;
  assign win_wrap  = (win_q == WIN_LAST);
  assign err_inc   = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;
  assign core_next = (core_q == CORE_LAST) ? '0 : core_q + 1'b1;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cd_d    = cd_q;
    to_d    = to_q;
    err_d   = err_q;
    core_d  = core_q;
    drain_d = drain_q;
    rreq_d  = rreq_q;
    irq_d   = 1'b0;
    terr_d  = terr_q;

    case (state_q)
      S_MONITOR: begin
        win_d = win_wrap ? '0 : win_q + 1'b1;
        // A fault on the wrap cycle is the first fault of the new window.
        if (win_wrap) begin
          err_d = fault_ev ? 8'd1 : 8'd0;
        end else if (fault_ev) begin
          err_d = err_inc;
        end
        if (fault_ev && (err_d == THRESH)) begin
          state_d = S_DRAIN;
          drain_d = 1'b1;
          irq_d   = 1'b1;
          to_d    = '0;
        end
      end

      S_DRAIN: begin
        // core_idle takes priority over a timeout in the same cycle.
        if (core_idle) begin
          state_d = S_RECONFIG;
          drain_d = 1'b0;
          rreq_d  = 1'b1;
        end else if (to_q == TO_LAST) begin
          state_d = S_RECONFIG;
          drain_d = 1'b0;
          rreq_d  = 1'b1;
          terr_d  = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      S_RECONFIG: begin
        if (reconfig_ack) begin
          state_d = S_COOLDOWN;
          rreq_d  = 1'b0;
          core_d  = core_next;
          cd_d    = '0;
        end
      end

      S_COOLDOWN: begin
        if (cd_q == CD_LAST) begin
          state_d = S_MONITOR;
          err_d   = 8'd0;
          win_d   = '0;
        end else begin
          cd_d = cd_q + 1'b1;
        end
      end

      default: begin
        state_d = S_MONITOR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_MONITOR;
      win_q   <= '0;
      cd_q    <= '0;
      to_q    <= '0;
      err_q   <= 8'd0;
      core_q  <= '0;
      drain_q <= 1'b0;
      rreq_q  <= 1'b0;
      irq_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cd_q    <= cd_d;
      to_q    <= to_d;
      err_q   <= err_d;
      core_q  <= core_d;
      drain_q <= drain_d;
      rreq_q  <= rreq_d;
      irq_q   <= irq_d;
      terr_q  <= terr_d;
    end
  end

  assign drain_req    = drain_q;
  assign reconfig_req = rreq_q;
  assign active_core  = core_q;
  assign err_count    = err_q;
  assign fault_irq    = irq_q;
  assign timeout_err  = terr_q;
  assign ctrl_state   = state_q;

`ifdef FAULT_LOG_EN
  logic [15:0] tot_q, tot_d;
  logic [7:0]  last_q, last_d;

  // Logging sees every fault event regardless of controller state.
  always_comb begin
    tot_d  = tot_q;
    last_d = last_q;
    if (fault_ev) begin
      tot_d  = (tot_q == 16'hFFFF) ? 16'hFFFF : tot_q + 16'd1;
      last_d = chk_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tot_q  <= 16'd0;
      last_q <= 8'd0;
    end else begin
      tot_q  <= tot_d;
      last_q <= last_d;
    end
  end

  assign total_faults  = tot_q;
  assign last_bad_data = last_q;
`else
  logic unused_chk_data;
  assign unused_chk_data = ^chk_data;
  assign total_faults    = 16'd0;
  assign last_bad_data   = 8'd0;
`endif

endmodule

// File: tb/tb_fault_reconfig_ctrl.sv
// Randomized episodes of fault bursts and switchovers; a monitor compares each DUT event against a queue of expectations.
module tb_fault_reconfig_ctrl;
  localparam int ERR_THRESH    = 4;
  localparam int WINDOW        = 256;
  localparam int COOLDOWN      = 64;
  localparam int DRAIN_TIMEOUT = 1024;
  localparam int NUM_CORES     = 2;
  localparam int CORE_W        = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              chk_valid = 1'b0, chk_fault = 1'b0, core_idle = 1'b0, reconfig_ack = 1'b0;
  logic [7:0]        chk_data = 8'd0;
  logic              drain_req, reconfig_req, fault_irq, timeout_err;
  logic [CORE_W-1:0] active_core;
  logic [7:0]        err_count, last_bad_data;
  logic [1:0]        ctrl_state;
  logic [15:0]       total_faults;

  fault_reconfig_ctrl #(
    .ERR_THRESH(ERR_THRESH), .WINDOW(WINDOW), .COOLDOWN(COOLDOWN),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .NUM_CORES(NUM_CORES), .CORE_W(CORE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chk_valid(chk_valid), .chk_fault(chk_fault),
    .chk_data(chk_data), .drain_req(drain_req), .core_idle(core_idle),
    .reconfig_req(reconfig_req), .reconfig_ack(reconfig_ack),
    .active_core(active_core), .err_count(err_count), .fault_irq(fault_irq),
    .timeout_err(timeout_err), .ctrl_state(ctrl_state),
    .total_faults(total_faults), .last_bad_data(last_bad_data)
  );

  typedef enum int {K_RST, K_IRQ, K_RREQ, K_CORE, K_MON} kind_e;
  typedef struct {
    kind_e kind;
    int    cyc;
    int    core;
    bit    terr;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   model_tot = 0, model_last = 0, snap_tot = 0, snap_last = 0;
  int   core_m = 0;
  bit   terr_m = 1'b0;
  bit   isf[int];
  int   cnt[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic              p_rst = 1'b0, p_rreq = 1'b0;
  logic [CORE_W-1:0] p_core = '0;
  logic [1:0]        p_state = 2'b00;

  task automatic handle(input kind_e k);
    exp_t e;
    int   etot, elast;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got event kind %0d at cycle %0d, expected none", k, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    chk("event_cycle", cyc, e.cyc);
    chk("timeout_err", int'(timeout_err), int'(e.terr));
    case (e.kind)
      K_RST: begin
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_ctrl_state", int'(ctrl_state), 0);
        chk("rst_active_core", int'(active_core), 0);
        chk("rst_drain_req", int'(drain_req), 0);
        chk("rst_reconfig_req", int'(reconfig_req), 0);
        chk("rst_fault_irq", int'(fault_irq), 0);
      end
      K_IRQ: begin
        chk("irq_err_count", int'(err_count), ERR_THRESH);
        chk("irq_drain_req", int'(drain_req), 1);
        chk("irq_ctrl_state", int'(ctrl_state), 1);
        chk("irq_active_core", int'(active_core), e.core);
      end
      K_RREQ: begin
        chk("rreq_drain_req", int'(drain_req), 0);
        chk("rreq_ctrl_state", int'(ctrl_state), 2);
      end
      K_CORE: begin
        chk("core_active_core", int'(active_core), e.core);
        chk("core_ctrl_state", int'(ctrl_state), 3);
        chk("core_reconfig_req", int'(reconfig_req), 0);
      end
      default: begin
        chk("mon_err_count", int'(err_count), 0);
        chk("mon_drain_req", int'(drain_req), 0);
        chk("mon_active_core", int'(active_core), e.core);
      end
    endcase
`ifdef FAULT_LOG_EN
    etot  = snap_tot;
    elast = snap_last;
`else
    etot  = 0;
    elast = 0;
`endif
    chk("total_faults", int'(total_faults), etot);
    chk("last_bad_data", int'(last_bad_data), elast);
  endtask

  always @(negedge clk) begin
    if (rst_n && !p_rst) begin
      handle(K_RST);
    end else if (rst_n) begin
      if (fault_irq) handle(K_IRQ);
      if (reconfig_req && !p_rreq) handle(K_RREQ);
      if (active_core != p_core) handle(K_CORE);
      if (ctrl_state == 2'b00 && p_state != 2'b00) handle(K_MON);
    end
    p_rst   <= rst_n;
    p_rreq  <= reconfig_req;
    p_core  <= active_core;
    p_state <= ctrl_state;
  end

  // ---------------- stimulus + reference model ----------------
  task automatic drive(input bit v, input bit f, input bit idle, input bit ack);
    chk_valid    = v;
    chk_fault    = f;
    core_idle    = idle;
    reconfig_ack = ack;
    chk_data     = 8'($urandom);
    snap_tot     = model_tot;
    snap_last    = model_last;
    if (!rst_n) begin
      model_tot  = 0;
      model_last = 0;
    end else if (v && f) begin
      if (model_tot < 65535) model_tot++;
      model_last = int'(chk_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    core_m = 0;
    terr_m = 1'b0;
    exp_q.push_back('{K_RST, cyc, 0, 1'b0});
    rst_n = 1'b1;
  endtask

  // mode 0: core goes idle after k cycles; 1: never idle (timeout); 2: idle on the timeout cycle
  task automatic episode(input int mode, input bit directed, input bit abort);
    int m0, hit, d0, r0, k, a, fin, prev, o, w;
    isf.delete();
    cnt.delete();
    m0 = cyc;
    if (directed) begin
      isf[10] = 1'b1; isf[20] = 1'b1; isf[30] = 1'b1; isf[40] = 1'b1;
      hit = 40;
    end else begin
      prev = -1;
      hit  = -1;
      while (hit < 0) begin
        if ($urandom_range(0, 3) == 0) o = ((prev + 1) / WINDOW + 1) * WINDOW - 1;
        else o = prev + int'($urandom_range(1, 100));
        isf[o] = 1'b1;
        w = (o + 1) / WINDOW;  // a fault on the last window cycle belongs to the next window
        if (!cnt.exists(w)) cnt[w] = 0;
        cnt[w]++;
        if (cnt[w] == ERR_THRESH) hit = o;
        prev = o;
      end
    end
    d0 = m0 + hit + 1;
    exp_q.push_back('{K_IRQ, d0, core_m, terr_m});
    k  = directed ? 5 : int'($urandom_range(0, 20));
    r0 = (mode == 0) ? d0 + k + 1 : d0 + DRAIN_TIMEOUT;
    if (mode == 1) terr_m = 1'b1;
    exp_q.push_back('{K_RREQ, r0, core_m, terr_m});
    if (!abort) begin
      a      = directed ? 3 : int'($urandom_range(0, 6));
      core_m = (core_m + 1) % NUM_CORES;
      exp_q.push_back('{K_CORE, r0 + a + 1, core_m, terr_m});
      fin    = r0 + a + 1 + COOLDOWN;
      exp_q.push_back('{K_MON, fin, core_m, terr_m});
    end else begin
      a   = 1000;
      fin = r0 + 2;
    end

    for (int c = m0; c < fin; c++) begin
      bit v, f, idle, ack;
      v    = 1'($urandom_range(0, 1));
      f    = 1'($urandom_range(0, 1));
      idle = 1'b0;
      ack  = 1'b0;
      if (c <= m0 + hit) begin
        if (isf.exists(c - m0)) begin
          v = 1'b1;
          f = 1'b1;
        end else if (v && f) begin
          f = 1'b0;
        end
        idle = ($urandom_range(0, 7) == 0);
        ack  = ($urandom_range(0, 15) == 0);
      end else if (c < r0) begin
        idle = (mode == 0 && c == d0 + k) || (mode == 2 && c == d0 + DRAIN_TIMEOUT - 1);
        ack  = ($urandom_range(0, 15) == 0);
      end else if (c <= r0 + a) begin
        ack = !abort && (c == r0 + a);
      end else begin
        idle = ($urandom_range(0, 3) == 0);
        ack  = ($urandom_range(0, 15) == 0);
      end
      drive(v, f, idle, ack);
    end
  endtask

  initial begin
    do_reset(3);
    episode(0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) begin
      int mode;
      if (i == 2) mode = 2;
      else if (i == 4) mode = 1;
      else mode = ($urandom_range(0, 9) == 0) ? 1 : 0;
      episode(mode, 1'b0, 1'b0);
    end
    episode(0, 1'b0, 1'b1);
    do_reset(2);
    episode(0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event: got nothing, expected event kind %0d at cycle %0d", int'(e.kind), e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
